// File: rtl/multiplier_if.sv
// Start/ready handshake and operand/result bus of the shift-add multiply-accumulate unit.
interface multiplier_if #(
  parameter int unsigned WIDTH = 8
);
  logic               sign;
  logic               start;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic [WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0] product;
  logic               ready;
  logic               busy;

  modport master (
    output sign, start, multiplicand, multiplier, addend,
    input  product, ready, busy
  );

  modport slave (
    input  sign, start, multiplicand, multiplier, addend,
    output product, ready, busy
  );
endinterface

// File: rtl/multiplier.sv
// Sequential shift-add multiply-accumulate: product = multiplicand * multiplier + addend,
// unsigned or two's complement, one partial product per cycle over WIDTH cycles.
module multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  multiplier_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q;
  logic [WIDTH-1:0] mult_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   addend_q;
  logic [PW-1:0]   product_q;
  logic [CW-1:0]   bits_q;
  logic            neg_q;
  logic            ready_q;
  logic            busy_q;

  logic [WIDTH-1:0] mcand_mag_c;
  logic [WIDTH-1:0] mult_mag_c;
  logic [PW-1:0]    addend_ext_c;
  logic [PW-1:0]    acc_signed_c;

  // Operand magnitudes; -2^(W-1) maps to 2^(W-1), which still fits unsigned in WIDTH bits.
  always_comb begin
    mcand_mag_c  = bus.multiplicand;
    mult_mag_c   = bus.multiplier;
    addend_ext_c = {{WIDTH{1'b0}}, bus.addend};
    if (bus.sign && bus.multiplicand[WIDTH-1]) begin
      mcand_mag_c = WIDTH'(0) - bus.multiplicand;
    end
    if (bus.sign && bus.multiplier[WIDTH-1]) begin
      mult_mag_c = WIDTH'(0) - bus.multiplier;
    end
    if (bus.sign) begin
      addend_ext_c = {{WIDTH{bus.addend[WIDTH-1]}}, bus.addend};
    end
  end

  always_comb begin
    acc_signed_c = acc_q;
    if (neg_q) begin
      acc_signed_c = PW'(0) - acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Start restarts from any state; otherwise step RUN -> FIX -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (bits_q == CW'(1)) state_d = FIX;
        FIX:     state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q   <= '0;
      mult_q    <= '0;
      acc_q     <= '0;
      addend_q  <= '0;
      product_q <= '0;
      bits_q    <= '0;
      neg_q     <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ready_q <= (state_d == DONE);
      busy_q  <= (state_d == RUN) || (state_d == FIX);
      if (bus.start) begin
        mcand_q  <= {{WIDTH{1'b0}}, mcand_mag_c};
        mult_q   <= mult_mag_c;
        addend_q <= addend_ext_c;
        neg_q    <= bus.sign & (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
        acc_q    <= '0;
        bits_q   <= CW'(WIDTH);
      end else begin
        case (state_q)
          RUN: begin
            if (mult_q[0]) begin
              acc_q <= acc_q + mcand_q;
            end
            mcand_q <= {mcand_q[PW-2:0], 1'b0};
            mult_q  <= {1'b0, mult_q[WIDTH-1:1]};
            bits_q  <= bits_q - CW'(1);
          end
          FIX:     product_q <= acc_signed_c + addend_q;
          default: ;
        endcase
      end
    end
  end

  assign bus.product = product_q;
  assign bus.ready   = ready_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_multiplier.sv
// Randomized and directed bench for multiplier, checked against a plain-arithmetic reference.
module tb_multiplier;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LAT   = WIDTH + 1;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  multiplier_if #(.WIDTH(WIDTH)) bus ();

  multiplier #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer arithmetic, wrapped to 2*WIDTH bits.
  function automatic logic [2*WIDTH-1:0] model(input logic s, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c);
    longint x, y, z, r;
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
      z = longint'($signed(c));
    end else begin
      x = longint'(a);
      y = longint'(b);
      z = longint'(c);
    end
    r = x * y + z;
    return (2*WIDTH)'(r);
  endfunction

  // Drive start for exactly one edge; returns #1 after that edge with operands scrambled.
  task automatic launch(input logic s, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c);
    @(negedge clk);
    bus.sign = s;
    bus.multiplicand = a;
    bus.multiplier = b;
    bus.addend = c;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.sign = 1'($urandom);
    bus.multiplicand = WIDTH'($urandom);
    bus.multiplier = WIDTH'($urandom);
    bus.addend = WIDTH'($urandom);
  endtask

  // Called #1 after the start edge; returns #1 after the edge that raises ready.
  task automatic wait_result(input string tag, input logic [2*WIDTH-1:0] exp);
    int k;
    int busy_cnt;
    k = 0;
    busy_cnt = 0;
    while (!bus.ready && k < 3 * LAT) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "_latency"}, 64'(k), 64'(LAT));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(LAT));
    check({tag, "_busy_at_ready"}, 64'(bus.busy), 64'd0);
    check({tag, "_product"}, 64'(bus.product), 64'(exp));
  endtask

  task automatic do_op(input string tag, input logic s, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c,
                       input logic [2*WIDTH-1:0] exp);
    launch(s, a, b, c);
    wait_result(tag, exp);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 64'(bus.ready), 64'd0);
    check({tag, "_hold"}, 64'(bus.product), 64'(exp));
  endtask

  task automatic count_ready(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.ready) cnt++;
    end
  endtask

  logic             d_s [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [WIDTH-1:0] d_a [9] = '{8'hFF, 8'h80, 8'hF9, 8'h80, 8'h80, 8'h1C, 8'hF2, 8'h00, 8'hFF};
  logic [WIDTH-1:0] d_b [9] = '{8'hFF, 8'h80, 8'h03, 8'h02, 8'h02, 8'h07, 8'h07, 8'h5A, 8'h00};
  logic [WIDTH-1:0] d_c [9] = '{8'hFF, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h04, 8'hFE, 8'hF0, 8'h33};
  logic [2*WIDTH-1:0] d_p [9] = '{16'hFF00, 16'h4000, 16'hFFE9, 16'h0100, 16'hFF00,
                                  16'h00C8, 16'hFF9C, 16'hFFF0, 16'h0033};

  initial begin
    int cnt;
    logic s;
    logic [WIDTH-1:0] a, b, c;
    logic [2*WIDTH-1:0] prev;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.sign = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    bus.addend = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_product", 64'(bus.product), 64'd0);
    check("reset_ready", 64'(bus.ready), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      check($sformatf("model_d%0d", i), 64'(model(d_s[i], d_a[i], d_b[i], d_c[i])), 64'(d_p[i]));
      do_op($sformatf("dir%0d", i), d_s[i], d_a[i], d_b[i], d_c[i], d_p[i]);
    end

    // Restart three cycles into RUN: only the second job may pulse ready.
    launch(1'b0, 8'h33, 8'h44, 8'h11);
    count_ready(2, cnt);
    check("restart_early_ready", 64'(cnt), 64'd0);
    launch(1'b0, 8'd5, 8'd6, 8'd0);
    wait_result("restart", 16'h001E);
    count_ready(2 * LAT, cnt);
    check("restart_no_extra", 64'(cnt), 64'd0);

    // Start held high never completes.
    @(negedge clk);
    bus.sign = 1'b0;
    bus.multiplicand = 8'd3;
    bus.multiplier = 8'd4;
    bus.addend = 8'd1;
    bus.start = 1'b1;
    count_ready(2 * LAT, cnt);
    check("held_start_ready", 64'(cnt), 64'd0);
    check("held_start_busy", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    wait_result("held_start", 16'd13);

    // Reset mid-run aborts with no later pulse.
    launch(1'b1, 8'h85, 8'h77, 8'h10);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_product", 64'(bus.product), 64'd0);
    check("abort_ready", 64'(bus.ready), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    count_ready(2 * LAT, cnt);
    check("abort_no_pulse", 64'(cnt), 64'd0);

    // Reset wins over simultaneous start.
    @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    check("rst_start_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    count_ready(2 * LAT, cnt);
    check("rst_start_no_pulse", 64'(cnt), 64'd0);
    check("rst_start_idle", 64'(bus.busy), 64'd0);

    // Random operations, every fourth chained back-to-back off the ready cycle.
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      c = WIDTH'($urandom);
      if (i % 4 == 3) begin
        launch(s, a, b, c);
        wait_result($sformatf("b2b_first%0d", i), model(s, a, b, c));
        prev = model(s, a, b, c);
        s = 1'($urandom);
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        c = WIDTH'($urandom);
        bus.sign = s;
        bus.multiplicand = a;
        bus.multiplier = b;
        bus.addend = c;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check($sformatf("b2b_keep%0d", i), 64'(bus.product), 64'(prev));
        wait_result($sformatf("b2b_second%0d", i), model(s, a, b, c));
      end else begin
        do_op($sformatf("rnd%0d", i), s, a, b, c, model(s, a, b, c));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
